add_round_key_keygen: RTL and testbench

- AddRoundKey stage of the iterative AES-128 encrypt datapath with on-the-fly key expansion.
- Consumes the 128-bit state from subByte_mixColumn, or the plaintext or final-round state from the round mux. XORs it with the current round key.
- Advances the key schedule one round per accepted state, so no round-key RAM is needed.
- Output feeds the next round's ShiftRows/SubByte input, or the ciphertext register after round 10.

---
 rtl/add_round_key_keygen_if.sv | 25 ++
 rtl/add_round_key_keygen.sv | 170 +++++++++++++++++
 tb/tb_add_round_key_keygen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_keygen_if.sv
// Bus bundle for the AES-128 AddRoundKey / key-schedule stage.
// The round mux and key source drive the master side; the stage is the slave.
interface add_round_key_keygen_if #(
   parameter int unsigned DATA_WIDTH = 128
);
   logic                  key_load;
   logic [DATA_WIDTH-1:0] key_in;
   logic                  ark_valid_in;
   logic [DATA_WIDTH-1:0] state_in;
   logic [DATA_WIDTH-1:0] state_out;
   logic                  ark_valid_out;
   logic [3:0]            round_out;
   logic                  key_ready;
   logic                  block_done;

   modport master (
      output key_load, key_in, ark_valid_in, state_in,
      input  state_out, ark_valid_out, round_out, key_ready, block_done
   );

   modport slave (
      input  key_load, key_in, ark_valid_in, state_in,
      output state_out, ark_valid_out, round_out, key_ready, block_done
   );
endinterface

// File: rtl/add_round_key_keygen.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion: each accepted state is
// XORed with the current round key and the schedule steps forward one round.
module add_round_key_keygen #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   add_round_key_keygen_if.slave  ark
);

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] saved_key_q, saved_key_d;
   logic [DATA_WIDTH-1:0] round_key_q, round_key_d;
   logic [3:0]            rc_q, rc_d;
   logic [DATA_WIDTH-1:0] state_out_q, state_out_d;
   logic [3:0]            round_out_q, round_out_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;

   logic                  ready;
   logic                  accept;
   logic                  last_round;
   logic [31:0]           rot_w, sub_w, t_w;
   logic [31:0]           w0_n, w1_n, w2_n, w3_n;

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] s;
      s = 8'h00;
      case (a)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
         8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
         8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
         8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
         8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
         8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
         8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
         8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
         8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
         8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
         8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
         8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
         8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Next round key from the live round-key register, consumed on the accept edge.
   always_comb begin
      rot_w = {round_key_q[23:0], round_key_q[31:24]};
      sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
      t_w   = sub_w ^ {rcon(rc_q + 4'd1), 24'h000000};
      w0_n  = round_key_q[127:96] ^ t_w;
      w1_n  = round_key_q[95:64]  ^ w0_n;
      w2_n  = round_key_q[63:32]  ^ w1_n;
      w3_n  = round_key_q[31:0]   ^ w2_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         saved_key_q <= '0;
         round_key_q <= '0;
         rc_q        <= '0;
         state_out_q <= '0;
         round_out_q <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         saved_key_q <= saved_key_d;
         round_key_q <= round_key_d;
         rc_q        <= rc_d;
         state_out_q <= state_out_d;
         round_out_q <= round_out_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ark.key_load) state_d = ACTIVE;
         ACTIVE:  state_d = ACTIVE;
         default: state_d = IDLE;
      endcase
   end

   // key_load takes priority over a coincident valid, which is dropped.
   always_comb begin
      ready      = (state_q == ACTIVE);
      accept     = ready && ark.ark_valid_in && !ark.key_load;
      last_round = (rc_q == 4'(NUM_ROUNDS));
   end

   always_comb begin
      saved_key_d = saved_key_q;
      round_key_d = round_key_q;
      rc_d        = rc_q;
      state_out_d = state_out_q;
      round_out_d = round_out_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      if (ark.key_load) begin
         saved_key_d = ark.key_in;
         round_key_d = ark.key_in;
         rc_d        = '0;
      end else if (accept) begin
         state_out_d = ark.state_in ^ round_key_q;
         round_out_d = rc_q;
         valid_d     = 1'b1;
         if (last_round) begin
            done_d      = 1'b1;
            round_key_d = saved_key_q;
            rc_d        = '0;
         end else begin
            round_key_d = {w0_n, w1_n, w2_n, w3_n};
            rc_d        = rc_q + 4'd1;
         end
      end
   end

   assign ark.state_out     = state_out_q;
   assign ark.ark_valid_out = valid_q;
   assign ark.round_out     = round_out_q;
   assign ark.key_ready     = ready;
   assign ark.block_done    = done_q;

endmodule

// File: tb/tb_add_round_key_keygen.sv
// Scoreboard bench for add_round_key_keygen: a full-expansion AES-128 key model
// predicts each keyed output; a monitor compares whatever the stage emits.
module tb_add_round_key_keygen;

   typedef struct {
      logic [127:0] st;
      logic [3:0]   rnd;
      logic         done;
   } exp_t;

   localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_FIPS  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C0_FIPS = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] R1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic clk;
   logic rst;
   add_round_key_keygen_if #(.DATA_WIDTH(128)) bus ();

   add_round_key_keygen #(.DATA_WIDTH(128), .NUM_ROUNDS(10)) dut (
      .clk (clk),
      .rst (rst),
      .ark (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   exp_t        sb_q[$];

   logic [7:0]   sbox_m [0:255];
   logic [127:0] m_rk   [0:10];
   int           m_rc;
   bit           m_loaded;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = x;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box from first principles: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         if (a != 0)
            for (int b = 1; b < 256; b++)
               if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rcv;
      rcv = 8'h01;
      w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rcv, 24'h000000};
            rcv = gmul(rcv, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model(input bit ld, input logic [127:0] k, input bit v,
                        input logic [127:0] s, output bit got, output exp_t e);
      got = 1'b0;
      e.st = '0; e.rnd = '0; e.done = 1'b0;
      if (ld) begin
         expand(k);
         m_rc = 0;
         m_loaded = 1'b1;
      end else if (v && m_loaded) begin
         e.st   = s ^ m_rk[m_rc];
         e.rnd  = 4'(m_rc);
         e.done = (m_rc == 10);
         got    = 1'b1;
         m_rc   = (m_rc == 10) ? 0 : m_rc + 1;
      end
   endtask

   task automatic drive(input bit ld, input logic [127:0] k, input bit v, input logic [127:0] s);
      bus.key_load     = ld;
      bus.key_in       = k;
      bus.ark_valid_in = v;
      bus.state_in     = s;
      @(posedge clk);
      #1;
      chk("key_ready", 128'(bus.key_ready), 128'(m_loaded));
   endtask

   task automatic step(input bit ld, input logic [127:0] k, input bit v, input logic [127:0] s);
      bit got;
      exp_t e;
      model(ld, k, v, s, got, e);
      if (got) sb_q.push_back(e);
      drive(ld, k, v, s);
   endtask

   task automatic step_known(input bit ld, input logic [127:0] k, input bit v, input logic [127:0] s,
                             input logic [127:0] xs, input logic [3:0] xr, input bit xd);
      bit got;
      exp_t e;
      model(ld, k, v, s, got, e);
      if (got) begin
         e.st = xs; e.rnd = xr; e.done = xd;
         sb_q.push_back(e);
      end
      drive(ld, k, v, s);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (bus.ark_valid_out) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got state_out %h round %0d, expected no output",
                     bus.state_out, bus.round_out);
         end else begin
            e = sb_q.pop_front();
            chk("state_out", bus.state_out, e.st);
            chk("round_out", 128'(bus.round_out), 128'(e.rnd));
            chk("block_done", 128'(bus.block_done), 128'(e.done));
         end
      end else if (bus.block_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL stray_block_done: got 1 expected 0");
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] k2, k3, s;
      build_sbox();
      m_rc = 0;
      m_loaded = 1'b0;
      rst = 1'b1;
      bus.key_load = 1'b0; bus.key_in = '0; bus.ark_valid_in = 1'b0; bus.state_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state_out", bus.state_out, '0);
      chk("rst_valid", 128'(bus.ark_valid_out), '0);
      chk("rst_round", 128'(bus.round_out), '0);
      chk("rst_key_ready", 128'(bus.key_ready), '0);
      chk("rst_block_done", 128'(bus.block_done), '0);
      rst = 1'b0;

      // valid with no key loaded is ignored
      step(1'b0, '0, 1'b1, rand128());
      step(1'b0, '0, 1'b0, '0);

      step(1'b1, K_FIPS, 1'b0, '0);
      step_known(1'b0, '0, 1'b1, P_FIPS, C0_FIPS, 4'd0, 1'b0);
      step(1'b0, '0, 1'b0, '0);

      // full schedule with zero states, then reuse of the saved key
      step(1'b1, K_FIPS, 1'b0, '0);
      for (int i = 0; i < 11; i++) begin
         if (i == 0)       step_known(1'b0, '0, 1'b1, '0, K_FIPS, 4'd0, 1'b0);
         else if (i == 1)  step_known(1'b0, '0, 1'b1, '0, R1_FIPS, 4'd1, 1'b0);
         else if (i == 10) step_known(1'b0, '0, 1'b1, '0, R10_FIPS, 4'd10, 1'b1);
         else              step(1'b0, '0, 1'b1, '0);
      end
      step_known(1'b0, '0, 1'b1, '0, K_FIPS, 4'd0, 1'b0);

      // key_load coincident with valid at rc=5
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, rand128());
      k2 = rand128();
      step(1'b1, k2, 1'b1, rand128());
      step_known(1'b0, '0, 1'b1, '0, k2, 4'd0, 1'b0);

      // async reset at rc=7
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, rand128());
      step(1'b0, '0, 1'b0, '0);
      #2 rst = 1'b1;
      #1;
      chk("arst_state_out", bus.state_out, '0);
      chk("arst_valid", 128'(bus.ark_valid_out), '0);
      chk("arst_round", 128'(bus.round_out), '0);
      chk("arst_key_ready", 128'(bus.key_ready), '0);
      chk("arst_block_done", 128'(bus.block_done), '0);
      m_loaded = 1'b0;
      m_rc = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, rand128());
      k3 = rand128();
      s = rand128();
      step(1'b1, k3, 1'b0, '0);
      step_known(1'b0, '0, 1'b1, s, s ^ k3, 4'd0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom % 24) == 0, rand128(), ($urandom % 4) != 0, rand128());

      repeat (3) step(1'b0, '0, 1'b0, '0);
      chk("scoreboard_drained", 128'(sb_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
